// File: rtl/labyrinth_pkg.sv
// Shared screen geometry, motion FSM state and velocity types for the labyrinth ball logic.
package labyrinth_pkg;

    localparam int unsigned H_ACTIVE = 1280;
    localparam int unsigned V_ACTIVE = 800;
    localparam int unsigned H_TOTAL  = 1680;
    localparam int unsigned V_TOTAL  = 828;
    localparam int unsigned X_RESET  = 640;
    localparam int unsigned Y_RESET  = 400;

    typedef enum logic [1:0] {IDLE, ACCEL, MOVE, CLAMP} motion_state_t;

    typedef logic signed [4:0] vel_t;

    // One frame of per-axis acceleration: a single held direction pushes, otherwise friction may bleed speed.
    function automatic vel_t accel_axis(input vel_t v, input logic inc, input logic dec,
                                        input logic fric, input vel_t vmax);
        vel_t r;
        r = v;
        if (inc && !dec) begin
            r = (v >= vmax) ? vmax : v + 5'sd1;
        end else if (dec && !inc) begin
            r = (v <= -vmax) ? -vmax : v - 5'sd1;
        end else if (fric) begin
            if (v > 5'sd0)
                r = v - 5'sd1;
            else if (v < 5'sd0)
                r = v + 5'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for one raw push-button; BALL_DEBOUNCE_EN adds a stable-count debouncer.
module btn_sync
`ifdef BALL_DEBOUNCE_EN
#(
    parameter int unsigned DEBOUNCE_CLKS = 65536
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sync_q <= '0;
        else
            sync_q <= {sync_q[0], btn};
    end

`ifdef BALL_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CLKS);

    logic [CW-1:0] stable_cnt;
    logic          level_q;

    // Level follows the synchronised input only after DEBOUNCE_CLKS consecutive clocks of disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_cnt <= '0;
            level_q    <= 1'b0;
        end else if (sync_q[1] == level_q) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CW'(DEBOUNCE_CLKS - 1)) begin
            stable_cnt <= '0;
            level_q    <= sync_q[1];
        end else begin
            stable_cnt <= stable_cnt + CW'(1);
        end
    end

    assign level = level_q;
`else
    assign level = sync_q[1];
`endif

endmodule

// File: rtl/ball_motion.sv
// Ball centre integrator: buttons -> per-frame velocity -> clamped/bouncing position, once per frame.
// Optional button debounce is enabled with the BALL_DEBOUNCE_EN macro.
module ball_motion
    import labyrinth_pkg::*;
#(
    parameter int unsigned FRAME_CLKS   = H_TOTAL * V_TOTAL,
    parameter int unsigned RADIUS       = 10,
    parameter int unsigned VMAX         = 8,
    parameter int unsigned FRICTION_DIV = 4
`ifdef BALL_DEBOUNCE_EN
    ,
    parameter int unsigned DEBOUNCE_CLKS = 65536
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [10:0] xcenter,
    output logic [9:0]  ycenter,
    output logic        frame_tick,
    output logic        hit_wall
);

    localparam int unsigned CNT_W = $clog2(FRAME_CLKS);
    localparam int unsigned FRIC_W = (FRICTION_DIV > 1) ? $clog2(FRICTION_DIV) : 1;

    localparam vel_t                V_MAX = 5'(VMAX);
    localparam logic signed [11:0]  X_LO  = 12'(RADIUS);
    localparam logic signed [11:0]  X_HI  = 12'(H_ACTIVE - 1 - RADIUS);
    localparam logic signed [10:0]  Y_LO  = 11'(RADIUS);
    localparam logic signed [10:0]  Y_HI  = 11'(V_ACTIVE - 1 - RADIUS);

    logic [3:0] btn_raw;
    logic [3:0] btn_lvl;
    logic       up_s, down_s, left_s, right_s;

    assign btn_raw = {btn_up, btn_down, btn_left, btn_right};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
`ifdef BALL_DEBOUNCE_EN
        btn_sync #(.DEBOUNCE_CLKS(DEBOUNCE_CLKS)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn_raw[gi]),
            .level (btn_lvl[gi])
        );
`else
        btn_sync u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn_raw[gi]),
            .level (btn_lvl[gi])
        );
`endif
    end

    assign {up_s, down_s, left_s, right_s} = btn_lvl;

    motion_state_t      state, state_d;
    logic [CNT_W-1:0]   frame_cnt;
    logic               tick_next;
    logic [FRIC_W-1:0]  fric_cnt, fric_d;
    logic               fric_wrap;
    vel_t               vx, vy, vx_d, vy_d;
    logic signed [11:0] px, px_d;
    logic signed [10:0] py, py_d;
    logic [10:0]        x_d;
    logic [9:0]         y_d;
    logic               hit_d;

    // ACCEL is entered on the same edge that raises frame_tick, so results land 3 clocks after the tick.
    assign tick_next = (frame_cnt == CNT_W'(FRAME_CLKS - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d   = state;
        fric_d    = fric_cnt;
        fric_wrap = 1'b0;
        vx_d      = vx;
        vy_d      = vy;
        px_d      = px;
        py_d      = py;
        x_d       = xcenter;
        y_d       = ycenter;
        hit_d     = 1'b0;

        case (state)
            IDLE: begin
                if (tick_next)
                    state_d = ACCEL;
            end
            ACCEL: begin
                fric_wrap = (fric_cnt == FRIC_W'(FRICTION_DIV - 1));
                fric_d    = fric_wrap ? '0 : fric_cnt + FRIC_W'(1);
                vx_d      = accel_axis(vx, right_s, left_s, fric_wrap, V_MAX);
                vy_d      = accel_axis(vy, down_s, up_s, fric_wrap, V_MAX);
                state_d   = MOVE;
            end
            MOVE: begin
                px_d    = $signed({1'b0, xcenter}) + 12'(vx);
                py_d    = $signed({1'b0, ycenter}) + 11'(vy);
                state_d = CLAMP;
            end
            CLAMP: begin
                if (px < X_LO) begin
                    x_d   = X_LO[10:0];
                    vx_d  = -vx;
                    hit_d = 1'b1;
                end else if (px > X_HI) begin
                    x_d   = X_HI[10:0];
                    vx_d  = -vx;
                    hit_d = 1'b1;
                end else begin
                    x_d = px[10:0];
                end

                if (py < Y_LO) begin
                    y_d   = Y_LO[9:0];
                    vy_d  = -vy;
                    hit_d = 1'b1;
                end else if (py > Y_HI) begin
                    y_d   = Y_HI[9:0];
                    vy_d  = -vy;
                    hit_d = 1'b1;
                end else begin
                    y_d = py[9:0];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt  <= '0;
            frame_tick <= 1'b0;
            fric_cnt   <= '0;
            vx         <= '0;
            vy         <= '0;
            px         <= '0;
            py         <= '0;
            xcenter    <= 11'(X_RESET);
            ycenter    <= 10'(Y_RESET);
            hit_wall   <= 1'b0;
        end else begin
            frame_cnt  <= (frame_cnt == CNT_W'(FRAME_CLKS - 1)) ? '0 : frame_cnt + CNT_W'(1);
            frame_tick <= tick_next;
            fric_cnt   <= fric_d;
            vx         <= vx_d;
            vy         <= vy_d;
            px         <= px_d;
            py         <= py_d;
            xcenter    <= x_d;
            ycenter    <= y_d;
            hit_wall   <= hit_d;
        end
    end

endmodule
